spi_cmd_decoder: RTL and testbench

- Sequences the byte stream from spi_slave (data/valid/sot/eot) into display-controller actions.
- Actions are framebuffer writes with address auto-increment, control-register writes, and a buffer-swap strobe.
- Sits between spi_slave and the framebuffer/register file, in the same clock domain.
- One SPI transaction (ss low to ss high) carries exactly one command.

---
 rtl/display_pkg.sv | 22 ++
 rtl/spi_cmd_decoder.sv | 111 +++++++++++
 tb/tb_spi_cmd_decoder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the display controller: command opcodes, decoder
// state encoding and default address widths.
package display_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 12;
    localparam int unsigned DEF_REG_ADDR_WIDTH = 3;

    localparam logic [7:0] CMD_FB_WRITE  = 8'h01;
    localparam logic [7:0] CMD_REG_WRITE = 8'h02;
    localparam logic [7:0] CMD_SWAP      = 8'h03;

    typedef enum logic [2:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StFbData,
        StRegAddr,
        StRegData,
        StDiscard
    } state_e;

endpackage

// File: rtl/spi_cmd_decoder.sv
// Turns the spi_slave byte stream into framebuffer writes, control-register
// writes and buffer-swap requests. One command per SPI transaction; all
// strobes are registered and fire one clock after the causing byte or eot.
module spi_cmd_decoder
    import display_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      rx_sot,
    input  logic                      rx_eot,
    output logic [ADDR_WIDTH-1:0]     fb_addr,
    output logic [7:0]                fb_data,
    output logic                      fb_we,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]                reg_data,
    output logic                      reg_we,
    output logic                      swap,
    output logic                      error,
    output logic                      busy
);

    state_e                    state_q;
    state_e                    after_byte;
    logic [7:0]                hi_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [REG_ADDR_WIDTH-1:0] reg_sel_q;

    logic sot_byte;
    logic data_byte;
    logic cmd_illegal;
    logic truncated;

    assign sot_byte    = rx_valid & rx_sot;
    assign data_byte   = rx_valid & ~rx_sot;
    assign cmd_illegal = !(rx_data inside {CMD_FB_WRITE, CMD_REG_WRITE, CMD_SWAP});
    assign busy        = (state_q != StIdle);

    // State reached after this cycle's byte, before any eot is applied; the
    // truncation check looks at this so a byte arriving with eot still counts.
    always_comb begin
        after_byte = state_q;
        if (sot_byte) begin
            case (rx_data)
                CMD_FB_WRITE:  after_byte = StAddrHi;
                CMD_REG_WRITE: after_byte = StRegAddr;
                default:       after_byte = StDiscard;
            endcase
        end else if (data_byte) begin
            case (state_q)
                StAddrHi:  after_byte = StAddrLo;
                StAddrLo:  after_byte = StFbData;
                StRegAddr: after_byte = StRegData;
                StRegData: after_byte = StDiscard;
                default:   after_byte = state_q;
            endcase
        end
    end

    assign truncated = rx_eot &
        (after_byte inside {StAddrHi, StAddrLo, StRegAddr, StRegData});

    // FSM, address counter and registered strobes/outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            addr_q    <= '0;
            reg_sel_q <= '0;
            fb_addr   <= '0;
            fb_data   <= '0;
            fb_we     <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
            reg_we    <= 1'b0;
            swap      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q <= rx_eot ? StIdle : after_byte;
            fb_we   <= data_byte && (state_q == StFbData);
            reg_we  <= data_byte && (state_q == StRegData);
            swap    <= sot_byte && (rx_data == CMD_SWAP);
            // A new sot while busy means the previous eot was missed.
            error   <= (sot_byte && ((state_q != StIdle) || cmd_illegal)) || truncated;

            if (data_byte) begin
                case (state_q)
                    StAddrHi: hi_q <= rx_data;
                    // Upper address bits beyond ADDR_WIDTH are dropped.
                    StAddrLo: addr_q <= ADDR_WIDTH'({hi_q, rx_data});
                    StFbData: begin
                        fb_addr <= addr_q;
                        fb_data <= rx_data;
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                    end
                    StRegAddr: reg_sel_q <= REG_ADDR_WIDTH'(rx_data);
                    StRegData: begin
                        reg_addr <= reg_sel_q;
                        reg_data <= rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: a transaction-level model predicts
// each strobe and its due cycle; a monitor checks DUT outputs every cycle.
module tb_spi_cmd_decoder;

    localparam int AW = 12;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_sot;
    logic          rx_eot;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          fb_we;
    logic [RW-1:0] reg_addr;
    logic [7:0]    reg_data;
    logic          reg_we;
    logic          swap;
    logic          error;
    logic          busy;

    always #5 clk = ~clk;

    spi_cmd_decoder #(
        .ADDR_WIDTH     (AW),
        .REG_ADDR_WIDTH (RW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_sot   (rx_sot),
        .rx_eot   (rx_eot),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_we    (fb_we),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .reg_we   (reg_we),
        .swap     (swap),
        .error    (error),
        .busy     (busy)
    );

    typedef struct {
        bit      fb;
        bit      rg;
        bit      sw;
        bit      er;
        int      due;
        logic [AW-1:0] fa;
        logic [7:0]    fd;
        logic [RW-1:0] ra;
        logic [7:0]    rd;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    bit  mon_en = 0;
    bit  exp_busy = 0;

    logic [AW-1:0] hold_fa = '0;
    logic [7:0]    hold_fd = '0;
    logic [RW-1:0] hold_ra = '0;
    logic [7:0]    hold_rd = '0;

    // Reference model: which command is open and how many bytes followed it.
    bit m_active = 0;
    int m_kind = 0;     // 0 = nothing to write (swap/illegal), 1 = fb, 2 = reg
    int m_idx = 0;
    int m_hi = 0;
    int m_base = 0;
    int m_ra = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void model_step(bit v, bit s, logic [7:0] d, bit e);
        ev_t ev;
        ev = '{default: 0};
        ev.due = cyc + 1;
        if (v && s) begin
            if (m_active) ev.er = 1;
            m_active = 1;
            m_idx = 0;
            if (d == 8'h01) m_kind = 1;
            else if (d == 8'h02) m_kind = 2;
            else begin
                m_kind = 0;
                if (d == 8'h03) ev.sw = 1;
                else ev.er = 1;
            end
        end else if (v && m_active) begin
            if (m_kind == 1) begin
                if (m_idx == 0) m_hi = int'(d);
                else if (m_idx == 1) m_base = ((m_hi * 256) + int'(d)) % (1 << AW);
                else begin
                    ev.fb = 1;
                    ev.fa = AW'((m_base + m_idx - 2) % (1 << AW));
                    ev.fd = d;
                end
            end else if (m_kind == 2) begin
                if (m_idx == 0) m_ra = int'(d) % (1 << RW);
                else if (m_idx == 1) begin
                    ev.rg = 1;
                    ev.ra = RW'(m_ra);
                    ev.rd = d;
                end
            end
            if (m_idx < 100000) m_idx++;
        end
        if (e) begin
            if (m_active && (m_kind != 0) && (m_idx < 2)) ev.er = 1;
            m_active = 0;
        end
        if (ev.fb || ev.rg || ev.sw || ev.er) exp_q.push_back(ev);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compare against the scoreboard entry due this cycle, if any.
    initial begin
        ev_t e;
        bit  have;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("busy", busy, exp_busy);
                have = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                if (have) begin
                    e = exp_q.pop_front();
                    chk("fb_we", fb_we, e.fb);
                    chk("reg_we", reg_we, e.rg);
                    chk("swap", swap, e.sw);
                    chk("error", error, e.er);
                end else begin
                    e = '{default: 0};
                    chk("no_strobe", {fb_we, reg_we, swap, error}, 4'b0000);
                end
                if (e.fb) begin
                    hold_fa = e.fa;
                    hold_fd = e.fd;
                end
                if (e.rg) begin
                    hold_ra = e.ra;
                    hold_rd = e.rd;
                end
                chk("fb_addr", fb_addr, hold_fa);
                chk("fb_data", fb_data, hold_fd);
                chk("reg_addr", reg_addr, hold_ra);
                chk("reg_data", reg_data, hold_rd);
            end
        end
    end

    task automatic drive(bit v, bit s, logic [7:0] d, bit e);
        rx_valid = v;
        rx_sot   = s;
        rx_data  = d;
        rx_eot   = e;
        model_step(v, s, d, e);
        @(posedge clk);
        exp_busy = m_active;
        #1;
        rx_valid = 0;
        rx_sot   = 0;
        rx_eot   = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        m_active = 0;
        m_kind = 0;
        m_idx = 0;
        @(posedge clk);
        exp_busy = 0;
        hold_fa = '0;
        hold_fd = '0;
        hold_ra = '0;
        hold_rd = '0;
        #1;
        rst = 0;
        chk("rst_strobes", {fb_we, reg_we, swap, error, busy}, 5'b00000);
        chk("rst_fb", {fb_addr, fb_data}, '0);
        chk("rst_reg", {reg_addr, reg_data}, '0);
    endtask

    // Send one transaction; optionally merge eot with the last byte or omit it.
    task automatic send(logic [7:0] b[$], bit eot_with_last, bit do_eot, int max_gap);
        for (int i = 0; i < b.size(); i++) begin
            drive(1, i == 0, b[i], eot_with_last && do_eot && (i == b.size() - 1));
            repeat ($urandom_range(0, max_gap)) drive(0, 0, 8'h00, 0);
        end
        if (do_eot && !eot_with_last) drive(0, 0, 8'h00, 1);
        drive(0, 0, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] b[$];
        rst = 1;
        rx_valid = 0;
        rx_sot = 0;
        rx_eot = 0;
        rx_data = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1;

        b = '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        send(b, 0, 1, 0);
        b = '{8'h01, 8'h0F, 8'hFF, 8'h11, 8'h22};
        send(b, 0, 1, 0);
        b = '{8'h02, 8'h05, 8'h7E, 8'h99};
        send(b, 0, 1, 0);
        b = '{8'h03};
        send(b, 0, 1, 0);
        b = '{8'h5A};
        send(b, 0, 1, 0);
        b = '{8'h01, 8'h00};
        send(b, 0, 1, 0);
        b = '{8'h01, 8'h00, 8'h20};
        send(b, 0, 0, 0);
        do_reset();
        drive(1, 0, 8'h44, 0);
        drive(0, 0, 8'h00, 0);
        b = '{8'h03};
        send(b, 0, 1, 0);
        // Byte together with eot in REG_DATA: write fires, no truncation.
        b = '{8'h02, 8'h03, 8'h5C};
        send(b, 1, 1, 0);

        for (int t = 0; t < 300; t++) begin
            int r;
            int len;
            bit rst_mid;
            r = $urandom_range(0, 99);
            len = $urandom_range(1, 8);
            b = {};
            if (r < 40) b.push_back(8'h01);
            else if (r < 70) b.push_back(8'h02);
            else if (r < 82) b.push_back(8'h03);
            else b.push_back(8'($urandom));
            for (int i = 1; i < len; i++) b.push_back(8'($urandom));
            if (b[0] == 8'h01 && len > 2 && $urandom_range(0, 3) == 0) begin
                b[1] = b[1] | 8'h0F;
                b[2] = 8'hFC;
            end
            if ($urandom_range(0, 9) == 0) drive(1, 0, 8'($urandom), 0);
            rst_mid = ($urandom_range(0, 29) == 0);
            send(b, $urandom_range(0, 3) == 0, !rst_mid && ($urandom_range(0, 9) != 0),
                 $urandom_range(0, 1) * 2);
            if (rst_mid) do_reset();
        end

        repeat (4) drive(0, 0, 8'h00, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
